// File: rtl/button_debounce_bank.sv
// Debounces NUM_BTN buttons using debounceClk as a sampling strobe. Outputs are a clean level plus press and release pulses.
// Define DEBOUNCE_AUTO_REPEAT_EN to re-pulse btn_press while a button stays held.
module button_debounce_bank #(
  parameter int NUM_BTN      = 4,
  parameter int STABLE_TICKS = 4,
  parameter int REPEAT_DELAY = 32,
  parameter int REPEAT_RATE  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               debounceClk,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release
);

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;

  localparam logic [7:0] STABLE_N = 8'(STABLE_TICKS);

  logic [NUM_BTN-1:0] r_btn_meta;
  logic [NUM_BTN-1:0] r_btn_sync;
  logic               r_dbc_meta;
  logic               r_dbc_sync;
  logic               r_dbc_d;
  logic               w_tick;

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_btn_meta <= '0;
      r_btn_sync <= '0;
      r_dbc_meta <= 1'b0;
      r_dbc_sync <= 1'b0;
      r_dbc_d    <= 1'b0;
    end else begin
      r_btn_meta <= btn_raw;
      r_btn_sync <= r_btn_meta;
      r_dbc_meta <= debounceClk;
      r_dbc_sync <= r_dbc_meta;
      r_dbc_d    <= r_dbc_sync;
    end
  end

  // One clk-wide strobe per debounceClk rising edge.
  assign w_tick = r_dbc_sync & ~r_dbc_d;

`ifndef DEBOUNCE_AUTO_REPEAT_EN
  // The repeat parameters only take effect when the feature is compiled in.
  logic w_unused_repeat_cfg;
  assign w_unused_repeat_cfg = ^{REPEAT_DELAY[0], REPEAT_RATE[0]};
`endif

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    state_t     r_state;
    logic [7:0] r_cnt;
    logic       r_level;
    logic       r_press;
    logic       r_release;
    logic       w_s;
    logic [7:0] w_cnt_inc;

    assign w_s       = r_btn_sync[i];
    assign w_cnt_inc = r_cnt + 8'd1;

    assign btn_level[i]   = r_level;
    assign btn_press[i]   = r_press;
    assign btn_release[i] = r_release;

`ifdef DEBOUNCE_AUTO_REPEAT_EN
    logic [15:0] r_rep;
    logic        r_rep_first;
    logic [15:0] w_rep_inc;
    logic        w_rep_fire;

    assign w_rep_inc  = r_rep + 16'd1;
    assign w_rep_fire = (w_rep_inc == (r_rep_first ? 16'(REPEAT_DELAY) : 16'(REPEAT_RATE)));
`endif

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_state     <= IDLE;
        r_cnt       <= '0;
        r_level     <= 1'b0;
        r_press     <= 1'b0;
        r_release   <= 1'b0;
`ifdef DEBOUNCE_AUTO_REPEAT_EN
        r_rep       <= '0;
        r_rep_first <= 1'b1;
`endif
      end else begin
        r_press   <= 1'b0;
        r_release <= 1'b0;
        if (w_tick) begin
          unique case (r_state)
            IDLE: begin
              if (w_s) begin
                if (STABLE_N == 8'd1) begin
                  r_state <= PRESSED;
                  r_level <= 1'b1;
                  r_press <= 1'b1;
                  r_cnt   <= '0;
`ifdef DEBOUNCE_AUTO_REPEAT_EN
                  r_rep       <= '0;
                  r_rep_first <= 1'b1;
`endif
                end else begin
                  r_state <= PRESS_WAIT;
                  r_cnt   <= 8'd1;
                end
              end
            end
            PRESS_WAIT: begin
              if (!w_s) begin
                r_state <= IDLE;
                r_cnt   <= '0;
              end else if (w_cnt_inc >= STABLE_N) begin
                r_state <= PRESSED;
                r_level <= 1'b1;
                r_press <= 1'b1;
                r_cnt   <= '0;
`ifdef DEBOUNCE_AUTO_REPEAT_EN
                r_rep       <= '0;
                r_rep_first <= 1'b1;
`endif
              end else begin
                r_cnt <= w_cnt_inc;
              end
            end
            PRESSED: begin
              if (!w_s) begin
                if (STABLE_N == 8'd1) begin
                  r_state   <= IDLE;
                  r_level   <= 1'b0;
                  r_release <= 1'b1;
                  r_cnt     <= '0;
`ifdef DEBOUNCE_AUTO_REPEAT_EN
                  r_rep       <= '0;
                  r_rep_first <= 1'b1;
`endif
                end else begin
                  r_state <= RELEASE_WAIT;
                  r_cnt   <= 8'd1;
                end
              end
`ifdef DEBOUNCE_AUTO_REPEAT_EN
              // Repeat count survives a release glitch; only IDLE or a fresh acceptance restarts it.
              else if (w_rep_fire) begin
                r_press     <= 1'b1;
                r_rep       <= '0;
                r_rep_first <= 1'b0;
              end else begin
                r_rep <= w_rep_inc;
              end
`endif
            end
            RELEASE_WAIT: begin
              if (w_s) begin
                r_state <= PRESSED;
                r_cnt   <= '0;
              end else if (w_cnt_inc >= STABLE_N) begin
                r_state   <= IDLE;
                r_level   <= 1'b0;
                r_release <= 1'b1;
                r_cnt     <= '0;
`ifdef DEBOUNCE_AUTO_REPEAT_EN
                r_rep       <= '0;
                r_rep_first <= 1'b1;
`endif
              end else begin
                r_cnt <= w_cnt_inc;
              end
            end
            default: begin
              r_state <= IDLE;
              r_cnt   <= '0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_button_debounce_bank.sv
// Scoreboard bench for button_debounce_bank: stimulus pushes expected pulses with cycle windows, a monitor pops and compares.
module tb_button_debounce_bank;
  localparam int NB = 4;
  // Aligned raw edge to pulse: tick phase +3, four ticks of 100 clk, minus the 10-cycle alignment offset.
  localparam int LAT = 393;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          debounceClk = 1'b0;
  logic [NB-1:0] btn_raw = '0;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] btn_press;
  logic [NB-1:0] btn_release;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [NB-1:0] press;
    logic [NB-1:0] rel;
    int            lo;
    int            hi;
    string         name;
  } exp_t;

  exp_t q[$];
  exp_t e_mon;

  button_debounce_bank #(
    .NUM_BTN(NB), .STABLE_TICKS(4), .REPEAT_DELAY(32), .REPEAT_RATE(8)
  ) dut (
    .clk(clk), .rst(rst), .debounceClk(debounceClk), .btn_raw(btn_raw),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial forever begin
    repeat (50) @(posedge clk);
    #1 debounceClk = ~debounceClk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_window(input string name, input int t, input int lo, input int hi);
    total++;
    if (t < lo || t > hi) begin
      bad++;
      $display("FAIL %s: pulse at cycle %0d, expected within [%0d,%0d]", name, t, lo, hi);
    end
  endtask

  task automatic expect_pulse(input string name, input logic [NB-1:0] p, input logic [NB-1:0] r,
                              input int t0, input int delta);
    exp_t e;
    e.press = p;
    e.rel   = r;
    e.lo    = t0 + delta - 3;
    e.hi    = t0 + delta + 3;
    e.name  = name;
    q.push_back(e);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (q.size() != 0 && n < 1000) begin
      @(posedge clk);
      n++;
    end
    #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL %s_drain: %0d expected pulses outstanding, expected 0", name, q.size());
      q.delete();
    end
  endtask

  // Step to 10 clk after a debounceClk rising edge so tick phase is known.
  task automatic align();
    @(posedge debounceClk);
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every visible pulse must match the oldest outstanding expectation.
  initial forever begin
    @(negedge clk);
    if ((btn_press | btn_release) != '0) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse: press=%b release=%b at cycle %0d, expected none",
                 btn_press, btn_release, cyc);
      end else begin
        e_mon = q.pop_front();
        check({e_mon.name, "_pulse"}, {24'b0, btn_press, btn_release}, {24'b0, e_mon.press, e_mon.rel});
        check_window({e_mon.name, "_time"}, cyc, e_mon.lo, e_mon.hi);
      end
    end else if (q.size() != 0 && cyc > q[0].hi) begin
      total++;
      bad++;
      $display("FAIL %s_missing: no pulse by cycle %0d, expected press=%b release=%b",
               q[0].name, cyc, q[0].press, q[0].rel);
      void'(q.pop_front());
    end
  end

  initial begin
    int t;
    idle(5);
    check("reset_level", 32'(btn_level), 32'h0);
    check("reset_press", 32'(btn_press), 32'h0);
    check("reset_release", 32'(btn_release), 32'h0);
    rst = 1'b0;

    // Clean press and release on bit 0.
    align();
    btn_raw = 4'b0001;
    expect_pulse("clean_press", 4'b0001, 4'b0000, cyc, LAT);
    idle(1000);
    wait_idle("clean_press");
    check("clean_level", 32'(btn_level), 32'h1);
    align();
    btn_raw = 4'b0000;
    expect_pulse("clean_release", 4'b0000, 4'b0001, cyc, LAT);
    idle(500);
    wait_idle("clean_release");
    check("clean_level_off", 32'(btn_level), 32'h0);

    // Bounce on bit 1: toggles every 30 clk for 600 clk, then settles high.
    align();
    for (int i = 0; i < 20; i++) begin
      btn_raw[1] = ~btn_raw[1];
      idle(30);
    end
    btn_raw[1] = 1'b1;
    expect_pulse("bounce_press", 4'b0010, 4'b0000, cyc, LAT);
    idle(600);
    wait_idle("bounce_press");
    check("bounce_level", 32'(btn_level), 32'h2);
    align();
    btn_raw[1] = 1'b0;
    expect_pulse("bounce_release", 4'b0000, 4'b0010, cyc, LAT);
    idle(500);
    wait_idle("bounce_release");

    // Release glitch on bit 2: two low samples must not release.
    align();
    btn_raw[2] = 1'b1;
    expect_pulse("glitch_press", 4'b0100, 4'b0000, cyc, LAT);
    idle(500);
    wait_idle("glitch_press");
    align();
    btn_raw[2] = 1'b0;
    idle(200);
    btn_raw[2] = 1'b1;
    idle(500);
    check("glitch_level_held", 32'(btn_level), 32'h4);
    align();
    btn_raw[2] = 1'b0;
    expect_pulse("glitch_release", 4'b0000, 4'b0100, cyc, LAT);
    idle(500);
    wait_idle("glitch_release");
    check("glitch_level_off", 32'(btn_level), 32'h0);

    // Simultaneous transitions on bits 3 and 0.
    align();
    btn_raw = 4'b1001;
    expect_pulse("simul_press", 4'b1001, 4'b0000, cyc, LAT);
    idle(500);
    wait_idle("simul_press");
    check("simul_level", 32'(btn_level), 32'h9);
    align();
    btn_raw = 4'b0000;
    expect_pulse("simul_release", 4'b0000, 4'b1001, cyc, LAT);
    idle(500);
    wait_idle("simul_release");

    // Reset after 3 qualifying ticks; a held button must requalify from scratch.
    align();
    btn_raw[3] = 1'b1;
    idle(300);
    rst = 1'b1;
    #1;
    check("rst_mid_level", 32'(btn_level), 32'h0);
    check("rst_mid_press", 32'(btn_press), 32'h0);
    check("rst_mid_release", 32'(btn_release), 32'h0);
    idle(20);
    @(posedge debounceClk);
    idle(60);
    rst = 1'b0;
    t = cyc;
    // Deassert while debounceClk is low: next tick is 43 cycles away, fourth at +343.
    expect_pulse("rst_requal", 4'b1000, 4'b0000, t, 343);
    idle(300);
    check("rst_level_pending", 32'(btn_level), 32'h0);
    idle(200);
    wait_idle("rst_requal");
    check("rst_level_after", 32'(btn_level), 32'h8);
    align();
    btn_raw[3] = 1'b0;
    expect_pulse("rst_release", 4'b0000, 4'b1000, cyc, LAT);
    idle(500);
    wait_idle("rst_release");

    // Long hold on bit 0 (58 ticks): repeats at acceptance +32, +40, +48 ticks when enabled.
    align();
    btn_raw[0] = 1'b1;
    t = cyc;
    expect_pulse("hold_press", 4'b0001, 4'b0000, t, LAT);
`ifdef DEBOUNCE_AUTO_REPEAT_EN
    expect_pulse("repeat_1", 4'b0001, 4'b0000, t, LAT + 3200);
    expect_pulse("repeat_2", 4'b0001, 4'b0000, t, LAT + 4000);
    expect_pulse("repeat_3", 4'b0001, 4'b0000, t, LAT + 4800);
`endif
    idle(5800);
    btn_raw[0] = 1'b0;
    expect_pulse("hold_release", 4'b0000, 4'b0001, cyc, LAT);
    idle(500);
    wait_idle("hold_release");
    check("final_level", 32'(btn_level), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
